// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: the bus between the front-end controller and the PC sequencer.
//   master: the controller. It drives the hold, branch, call and return requests
//           and the targets, and it reads back the PC and the status flags.
//   slave : the sequencer. It reads the requests and drives the PC and the flags.
//   Signals:
//     hlt, branch, cond[2:0], Z, N, V, addr_src  request and condition inputs
//     in_addr_imm, in_addr_reg                   relative offset and absolute target
//     call, ret                                  return-address stack control
//     out_addr, pcs_out                          current PC and PC+STEP
//     halted, ras_empty, ras_full,
//     ras_overflow, ras_underflow, misalign      status flags
interface pc_sequencer_if #(
  parameter int unsigned PC_W = 16
);
  logic            hlt;
  logic            branch;
  logic [2:0]      cond;
  logic            Z;
  logic            N;
  logic            V;
  logic            addr_src;
  logic [PC_W-1:0] in_addr_imm;
  logic [PC_W-1:0] in_addr_reg;
  logic            call;
  logic            ret;
  logic [PC_W-1:0] out_addr;
  logic [PC_W-1:0] pcs_out;
  logic            halted;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_overflow;
  logic            ras_underflow;
  logic            misalign;

  modport master (
    output hlt, branch, cond, Z, N, V, addr_src, in_addr_imm, in_addr_reg, call, ret,
    input  out_addr, pcs_out, halted, ras_empty, ras_full, ras_overflow, ras_underflow,
           misalign
  );

  modport slave (
    input  hlt, branch, cond, Z, N, V, addr_src, in_addr_imm, in_addr_reg, call, ret,
    output out_addr, pcs_out, halted, ras_empty, ras_full, ras_overflow, ras_underflow,
           misalign
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a return-address stack (RAS).
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : pc_sequencer_if.slave. It carries the requests (hlt, branch, cond, flags,
//         targets, call, ret) and the results (out_addr, pcs_out and the status flags).
// Next-PC priority: rst > hlt > ret > taken branch > increment by STEP.
// All outputs are registered except pcs_out, which is out_addr + STEP.
// Optional macro ALIGN_CHECK_EN: a misaligned redirect target loads TRAP_PC and
// pulses misalign. When the macro is undefined, the low target bits are cleared.
module pc_sequencer #(
  parameter int unsigned     PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int unsigned     STEP      = 2,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] TRAP_PC   = PC_W'(16'hFFF0)
) (
  input logic            clk,
  input logic            rst,
  pc_sequencer_if.slave  bus
);
  localparam int unsigned     PTR_W    = $clog2(RAS_DEPTH);
  localparam int unsigned     CNT_W    = $clog2(RAS_DEPTH + 1);
  localparam logic [PC_W-1:0] LOW_MASK = PC_W'(STEP - 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  pc_q, pc_d, pcs, br_tgt, raw_tgt, tgt;
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, push_ptr, pop_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             halted_q, ovf_q, unf_q, mis_q;
  logic             cond_ok, taken, ras_empty, ras_full;
  logic             redirect, push, pop, unf_set, bad_align;

  assign pcs       = pc_q + PC_W'(STEP);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_MAX);

  always_comb begin
    cond_ok = 1'b0;
    case (bus.cond)
      3'b000: cond_ok = !bus.Z;
      3'b001: cond_ok = bus.Z;
      3'b010: cond_ok = !bus.Z && !bus.N;
      3'b011: cond_ok = bus.N;
      3'b100: cond_ok = bus.Z || !bus.N;
      3'b101: cond_ok = bus.Z || bus.N;
      3'b110: cond_ok = bus.V;
      default: cond_ok = 1'b1;
    endcase
  end

  assign taken  = bus.branch && cond_ok;
  assign br_tgt = bus.addr_src ? (pcs + bus.in_addr_imm) : bus.in_addr_reg;

  // The top pointer addresses the newest entry. A push that arrives while the
  // stack is full lands on the oldest slot, because the buffer is circular.
  assign push_ptr = (top_q == PTR_MAX) ? '0 : top_q + PTR_W'(1);
  assign pop_ptr  = (top_q == '0) ? PTR_MAX : top_q - PTR_W'(1);

  always_comb begin
    redirect = 1'b0;
    raw_tgt  = br_tgt;
    push     = 1'b0;
    pop      = 1'b0;
    unf_set  = 1'b0;
    if (!bus.hlt) begin
      if (bus.ret) begin
        // ret takes precedence over any branch or call in the same cycle.
        // A ret on an empty stack falls through to the increment.
        if (!ras_empty) begin
          redirect = 1'b1;
          raw_tgt  = ras_mem[top_q];
          pop      = 1'b1;
        end else begin
          unf_set  = 1'b1;
        end
      end else if (taken) begin
        redirect = 1'b1;
        push     = bus.call;
      end
    end
  end

`ifdef ALIGN_CHECK_EN
  assign bad_align = redirect && ((raw_tgt & LOW_MASK) != '0);
  assign tgt       = bad_align ? TRAP_PC : raw_tgt;
`else
  logic unused_trap;
  assign unused_trap = ^TRAP_PC;
  assign bad_align   = 1'b0;
  assign tgt         = raw_tgt & ~LOW_MASK;
`endif

  assign pc_d = bus.hlt ? pc_q : (redirect ? tgt : pcs);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      top_q    <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= bus.hlt;
      mis_q    <= bad_align;
      if (push) begin
        top_q <= push_ptr;
        if (ras_full) ovf_q <= 1'b1;
        else          cnt_q <= cnt_q + CNT_W'(1);
      end else if (pop) begin
        top_q <= pop_ptr;
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (unf_set) unf_q <= 1'b1;
    end
  end

  // The storage itself needs no reset. Clearing the count on reset discards the contents.
  always_ff @(posedge clk) begin
    if (!rst && push) ras_mem[push_ptr] <= pcs;
  end

  assign bus.out_addr      = pc_q;
  assign bus.pcs_out       = pcs;
  assign bus.halted        = halted_q;
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_full      = ras_full;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
  assign bus.misalign      = mis_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven vectors for the PC sequencer in its default
// configuration (PC_W 16, STEP 2, RAS_DEPTH 4). Hand-written sequences follow for
// hold, reset during a hold, and target alignment.
module tb_pc_sequencer;
  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  pc_sequencer_if #(.PC_W(16)) bus ();

  pc_sequencer #(.PC_W(16), .RESET_PC(16'h0000), .STEP(2), .RAS_DEPTH(4),
                 .TRAP_PC(16'hFFF0)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        rst;
    logic        br;
    logic [2:0]  cond;
    logic        z, n, v, src;
    logic [15:0] imm, rg;
    logic        call, ret;
    logic [15:0] pc;
    logic        emp, full, ovf, unf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic b, input logic [2:0] c,
                              input logic z, input logic n, input logic v,
                              input logic s, input logic [15:0] im, input logic [15:0] rg,
                              input logic ca, input logic re, input logic [15:0] pc,
                              input logic em, input logic fu, input logic ov,
                              input logic un);
    vec_t t;
    t.rst = r; t.br = b; t.cond = c; t.z = z; t.n = n; t.v = v; t.src = s;
    t.imm = im; t.rg = rg; t.call = ca; t.ret = re; t.pc = pc;
    t.emp = em; t.full = fu; t.ovf = ov; t.unf = un;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.hlt = 0; bus.branch = 0; bus.cond = 3'd7; bus.Z = 0; bus.N = 0; bus.V = 0;
    bus.addr_src = 0; bus.in_addr_imm = '0; bus.in_addr_reg = '0; bus.call = 0;
    bus.ret = 0;
  endtask

  task automatic jump(input logic [15:0] reg_t, input logic ca);
    idle();
    bus.branch = 1; bus.in_addr_reg = reg_t; bus.call = ca;
  endtask

  initial begin
    // Columns: rst br cond z n v src imm rg call ret | pc emp full ovf unf
    tbl.push_back(mk(1,0,3'd0,0,0,0,0,16'h0,16'd0,  0,0, 16'd0,  1,0,0,0));
    tbl.push_back(mk(0,0,3'd0,0,0,0,0,16'h0,16'd0,  0,0, 16'd2,  1,0,0,0));
    tbl.push_back(mk(0,0,3'd0,0,0,0,0,16'h0,16'd0,  0,0, 16'd4,  1,0,0,0));
    tbl.push_back(mk(0,0,3'd0,0,0,0,0,16'h0,16'd0,  0,0, 16'd6,  1,0,0,0));
    tbl.push_back(mk(1,0,3'd0,0,0,0,0,16'h0,16'd0,  0,0, 16'd0,  1,0,0,0));
    tbl.push_back(mk(0,0,3'd0,0,0,0,0,16'h0,16'd0,  0,0, 16'd2,  1,0,0,0));
    tbl.push_back(mk(0,1,3'd0,1,0,0,0,16'h0,16'd10, 0,0, 16'd4,  1,0,0,0));
    tbl.push_back(mk(0,1,3'd0,0,0,0,0,16'h0,16'd10, 0,0, 16'd10, 1,0,0,0));
    tbl.push_back(mk(0,1,3'd4,0,1,0,0,16'h0,16'd50, 0,0, 16'd12, 1,0,0,0));
    tbl.push_back(mk(0,1,3'd4,1,1,0,0,16'h0,16'd50, 0,0, 16'd50, 1,0,0,0));
    tbl.push_back(mk(0,1,3'd6,0,0,1,0,16'h0,16'd100,0,0, 16'd100,1,0,0,0));
    tbl.push_back(mk(0,1,3'd7,0,1,0,0,16'h0,16'd20, 0,0, 16'd20, 1,0,0,0));
    tbl.push_back(mk(0,1,3'd1,0,0,0,0,16'h0,16'd30, 0,0, 16'd22, 1,0,0,0));
    tbl.push_back(mk(0,1,3'd1,1,0,0,0,16'h0,16'd30, 0,0, 16'd30, 1,0,0,0));
    tbl.push_back(mk(0,1,3'd2,0,0,0,0,16'h0,16'd60, 0,0, 16'd60, 1,0,0,0));
    tbl.push_back(mk(0,1,3'd2,0,1,0,0,16'h0,16'd90, 0,0, 16'd62, 1,0,0,0));
    tbl.push_back(mk(0,1,3'd3,0,1,0,0,16'h0,16'd90, 0,0, 16'd90, 1,0,0,0));
    tbl.push_back(mk(0,1,3'd5,0,0,0,0,16'h0,16'd120,0,0, 16'd92, 1,0,0,0));
    tbl.push_back(mk(0,1,3'd5,0,1,0,0,16'h0,16'd120,0,0, 16'd120,1,0,0,0));
    tbl.push_back(mk(0,1,3'd6,0,0,0,0,16'h0,16'd0,  0,0, 16'd122,1,0,0,0));
    tbl.push_back(mk(0,1,3'd7,1,1,1,0,16'h0,16'd20, 0,0, 16'd20, 1,0,0,0));
    // PC-relative with a negative offset, then wrap at the top of the address space
    tbl.push_back(mk(0,1,3'd7,0,0,0,1,16'hFFF0,16'd0,0,0,16'd6, 1,0,0,0));
    tbl.push_back(mk(0,1,3'd7,0,0,0,0,16'h0,16'hFFFE,0,0,16'hFFFE,1,0,0,0));
    tbl.push_back(mk(0,0,3'd0,0,0,0,0,16'h0,16'd0,  0,0, 16'd0,  1,0,0,0));
    // call / ret
    tbl.push_back(mk(0,1,3'd7,0,0,0,0,16'h0,16'd10, 0,0, 16'd10, 1,0,0,0));
    tbl.push_back(mk(0,1,3'd7,0,0,0,0,16'h0,16'd40, 1,0, 16'd40, 0,0,0,0));
    tbl.push_back(mk(0,0,3'd0,0,0,0,0,16'h0,16'd0,  0,0, 16'd42, 0,0,0,0));
    tbl.push_back(mk(0,0,3'd0,0,0,0,0,16'h0,16'd0,  0,0, 16'd44, 0,0,0,0));
    tbl.push_back(mk(0,0,3'd0,0,0,0,0,16'h0,16'd0,  0,1, 16'd12, 1,0,0,0));
    tbl.push_back(mk(0,1,3'd7,0,0,0,0,16'h0,16'd80, 1,0, 16'd80, 0,0,0,0));
    tbl.push_back(mk(0,1,3'd7,0,0,0,0,16'h0,16'd200,1,1, 16'd14, 1,0,0,0));
    tbl.push_back(mk(0,0,3'd0,0,0,0,0,16'h0,16'd0,  0,0, 16'd16, 1,0,0,0));
    tbl.push_back(mk(0,1,3'd0,1,0,0,0,16'h0,16'd300,1,0, 16'd18, 1,0,0,0));
    tbl.push_back(mk(0,0,3'd7,0,0,0,0,16'h0,16'd300,1,0, 16'd20, 1,0,0,0));
    // overflow then underflow
    tbl.push_back(mk(0,1,3'd7,0,0,0,0,16'h0,16'd0,  0,0, 16'd0,  1,0,0,0));
    tbl.push_back(mk(0,1,3'd7,0,0,0,0,16'h0,16'd100,1,0, 16'd100,0,0,0,0));
    tbl.push_back(mk(0,1,3'd7,0,0,0,0,16'h0,16'd200,1,0, 16'd200,0,0,0,0));
    tbl.push_back(mk(0,1,3'd7,0,0,0,0,16'h0,16'd300,1,0, 16'd300,0,0,0,0));
    tbl.push_back(mk(0,1,3'd7,0,0,0,0,16'h0,16'd400,1,0, 16'd400,0,1,0,0));
    tbl.push_back(mk(0,1,3'd7,0,0,0,0,16'h0,16'd500,1,0, 16'd500,0,1,1,0));
    tbl.push_back(mk(0,0,3'd0,0,0,0,0,16'h0,16'd0,  0,1, 16'd402,0,0,1,0));
    tbl.push_back(mk(0,0,3'd0,0,0,0,0,16'h0,16'd0,  0,1, 16'd302,0,0,1,0));
    tbl.push_back(mk(0,0,3'd0,0,0,0,0,16'h0,16'd0,  0,1, 16'd202,0,0,1,0));
    tbl.push_back(mk(0,0,3'd0,0,0,0,0,16'h0,16'd0,  0,1, 16'd102,1,0,1,0));
    tbl.push_back(mk(0,1,3'd7,0,0,0,0,16'h0,16'd999,0,1, 16'd104,1,0,1,1));
    tbl.push_back(mk(0,0,3'd0,0,0,0,0,16'h0,16'd0,  0,0, 16'd106,1,0,1,1));
    tbl.push_back(mk(1,0,3'd0,0,0,0,0,16'h0,16'd0,  0,0, 16'd0,  1,0,0,0));

    idle();
    rst = 1;
    tick();
    chk("reset out_addr", bus.out_addr, 16'd0);
    chk("reset pcs_out", bus.pcs_out, 16'd2);
    chk("reset ras_empty", bus.ras_empty, 1);
    chk("reset ras_full", bus.ras_full, 0);
    chk("reset flags", {bus.halted, bus.ras_overflow, bus.ras_underflow, bus.misalign}, 0);
    rst = 0;

    foreach (tbl[i]) begin
      logic [15:0] pcs_exp;
      rst = tbl[i].rst;
      bus.hlt = 0; bus.branch = tbl[i].br; bus.cond = tbl[i].cond;
      bus.Z = tbl[i].z; bus.N = tbl[i].n; bus.V = tbl[i].v; bus.addr_src = tbl[i].src;
      bus.in_addr_imm = tbl[i].imm; bus.in_addr_reg = tbl[i].rg;
      bus.call = tbl[i].call; bus.ret = tbl[i].ret;
      tick();
      pcs_exp = tbl[i].pc + 16'd2;
      chk($sformatf("v%0d out_addr", i), bus.out_addr, tbl[i].pc);
      chk($sformatf("v%0d pcs_out", i), bus.pcs_out, pcs_exp);
      chk($sformatf("v%0d ras_empty", i), bus.ras_empty, tbl[i].emp);
      chk($sformatf("v%0d ras_full", i), bus.ras_full, tbl[i].full);
      chk($sformatf("v%0d ras_overflow", i), bus.ras_overflow, tbl[i].ovf);
      chk($sformatf("v%0d ras_underflow", i), bus.ras_underflow, tbl[i].unf);
      chk($sformatf("v%0d misalign", i), bus.misalign, 0);
    end
    rst = 0;

    // A hold with a ret and a taken call pending leaves the PC and the stack alone.
    jump(16'd40, 1); tick();
    chk("hold pre-call pc", bus.out_addr, 16'd40);
    chk("hold pre-call empty", bus.ras_empty, 0);
    jump(16'd300, 1); bus.ret = 1; bus.hlt = 1; tick();
    chk("hold pc", bus.out_addr, 16'd40);
    chk("hold halted", bus.halted, 1);
    chk("hold empty", bus.ras_empty, 0);
    tick();
    chk("hold2 pc", bus.out_addr, 16'd40);
    chk("hold2 full", bus.ras_full, 0);
    bus.hlt = 0; tick();
    chk("release ret pc", bus.out_addr, 16'd2);
    chk("release halted", bus.halted, 0);
    chk("release empty", bus.ras_empty, 1);
    chk("release underflow", bus.ras_underflow, 0);

    // A reset during a hold discards the stack.
    jump(16'd40, 1); tick();
    chk("pre-rst empty", bus.ras_empty, 0);
    idle(); bus.hlt = 1; rst = 1; tick();
    chk("rst-in-hold pc", bus.out_addr, 16'd0);
    chk("rst-in-hold empty", bus.ras_empty, 1);
    chk("rst-in-hold halted", bus.halted, 0);
    rst = 0; idle(); bus.ret = 1; tick();
    chk("post-rst ret pc", bus.out_addr, 16'd2);
    chk("post-rst underflow", bus.ras_underflow, 1);

    // Alignment of odd targets
    idle(); rst = 1; tick(); rst = 0;
    jump(16'd41, 0); tick();
`ifdef ALIGN_CHECK_EN
    chk("odd reg pc", bus.out_addr, 16'hFFF0);
    chk("odd reg misalign", bus.misalign, 1);
`else
    chk("odd reg pc", bus.out_addr, 16'd40);
    chk("odd reg misalign", bus.misalign, 0);
`endif
    idle(); tick();
    chk("misalign clears", bus.misalign, 0);
    idle(); bus.branch = 1; bus.addr_src = 1; bus.in_addr_imm = 16'd3; tick();
`ifdef ALIGN_CHECK_EN
    chk("odd rel pc", bus.out_addr, 16'hFFF0);
`else
    chk("odd rel pc", bus.out_addr, 16'd46);
`endif
    jump(16'd41, 1); tick();
    chk("odd call empty", bus.ras_empty, 0);
    idle(); bus.ret = 1; tick();
`ifdef ALIGN_CHECK_EN
    chk("odd call ret pc", bus.out_addr, 16'hFFF2);
`else
    chk("odd call ret pc", bus.out_addr, 16'd48);
`endif
    chk("odd call ret empty", bus.ras_empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the processor front end. It is the successor to the fixed 16-bit PC updater. It adds:
- configurable PC width, reset vector and instruction step
- PC-relative immediate targets
- a hardware return-address stack (RAS) for call/return
- status flags for halt and RAS faults.

It drives the instruction-memory address and the PC+step value consumed by the decode and writeback stages.

Parameters:
PC_W, 16, PC and address width in bits
RESET_PC, 0, value loaded into the PC on reset
STEP, 2, PC increment per instruction; must be a power of two
RAS_DEPTH, 4, number of return-address stack entries (2..16)
TRAP_PC, 16'hFFF0, redirect vector on a misaligned target (used only with ALIGN_CHECK_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
hlt  in  1  hold PC while high (level sensitive)
branch  in  1  branch or jump request this cycle
cond  in  3  condition code
Z  in  1  zero flag
N  in  1  negative flag
V  in  1  overflow flag
addr_src  in  1  0: target = in_addr_reg; 1: target = pcs_out + in_addr_imm
in_addr_imm  in  PC_W  signed PC-relative offset
in_addr_reg  in  PC_W  absolute register target
call  in  1  qualifies branch as a call; pushes the return address when the branch is taken
ret  in  1  return: next PC = RAS top, then pop
out_addr  out  PC_W  current PC (registered)
pcs_out  out  PC_W  out_addr + STEP (combinational, modulo 2^PC_W)
halted  out  1  registered copy of hlt
ras_empty  out  1  RAS holds 0 entries
ras_full  out  1  RAS holds RAS_DEPTH entries
ras_overflow  out  1  sticky; set when a push occurs while the RAS is full
ras_underflow  out  1  sticky; set when ret is asserted while the RAS is empty
misalign  out  1  one-cycle pulse on a misaligned redirect (ALIGN_CHECK_EN only)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - out_addr = RESET_PC
  - RAS count = 0, so ras_empty = 1 and ras_full = 0
  - halted, ras_overflow, ras_underflow, misalign = 0
- Timing: every output except pcs_out is registered. The next PC is computed from the current-cycle inputs and is visible after the following posedge (1-cycle latency).
- Next-PC priority:
  1. rst
  2. hlt (PC and RAS unchanged)
  3. ret
  4. taken branch
  5. increment by STEP
- Taken branch = branch & condition true. Conditions:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: Z | !N
  - 101 LE: Z | N
  - 110 OV: V
  - 111 always; flags are don't-care
- Target arithmetic: PC-relative targets are pcs_out + in_addr_imm, two's complement, truncated to PC_W bits (wraps). Increment also wraps at 2^PC_W.
- Call:
  - On a taken branch with call = 1, push pcs_out.
  - call with an untaken branch, or with branch = 0: no push.
- Ret:
  - RAS non-empty: PC loads the top entry and count decrements.
  - RAS empty: PC increments by STEP and ras_underflow is set.
  - ret overrides branch and call in the same cycle; no push occurs.
- RAS storage:
  - Circular buffer with a top pointer.
  - Push while full overwrites the oldest entry, count stays RAS_DEPTH, and ras_overflow is set.
  - The sticky flags clear only on rst.
- hlt:
  - All inputs are ignored, including a pending ret or call.
  - halted follows hlt with a 1-cycle delay.
  - When hlt deasserts, the instruction presented that cycle executes normally.
- Reset during a hold or mid-sequence: rst wins and the RAS contents are discarded.

Optional Feature:
Macro: ALIGN_CHECK_EN
- With the macro defined:
  - A redirect (branch or ret) whose target has nonzero bits [log2(STEP)-1:0] loads TRAP_PC instead of the target.
  - misalign pulses for 1 cycle.
  - A call push still occurs.
- Without the macro:
  - The low log2(STEP) bits of every target are forced to 0.
  - misalign is tied to 0.

Test Plan:
1. Reset and increment (defaults): rst high for 1 cycle -> out_addr = 0, pcs_out = 2; 3 free cycles -> out_addr 2, 4, 6; flags 0, ras_empty = 1.
2. Condition table from PC 2, addr_src = 0:
   - cond 000, Z = 1, reg = 10 -> 4; then Z = 0 -> 10
   - cond 100, Z = 0, N = 1, reg = 50 -> 12; then Z = 1 -> 50
   - cond 110, V = 1, reg = 100 -> 100
   - cond 111 with Z/N/V = x -> jumps
3. PC-relative with wrap:
   - PC 20, addr_src = 1, imm = 16'hFFF0, cond 111 -> 6
   - PC 16'hFFFE, branch = 0 -> 0
4. Call/return:
   - PC 10, call with cond 111, reg = 40 -> 40, ras_empty = 0
   - two increments -> 44
   - ret -> 12, ras_empty = 1
   - ret together with a taken call branch -> ret wins, no push
5. RAS overflow/underflow:
   - 5 calls from PCs 0, 100, 200, 300, 400 -> ras_overflow = 1
   - 4 rets -> 402, 302, 202, 102
   - 5th ret -> PC + 2, ras_underflow = 1; both flags stay set until rst
6. hlt:
   - hlt asserted with ret pending and RAS non-empty -> PC and RAS held, halted = 1 next cycle
   - hlt deasserted -> ret executes
   - ALIGN_CHECK_EN build: reg target 41 -> TRAP_PC, misalign pulses once
